pcm_dma_feeder: RTL



---
 rtl/pcm_dma_feeder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pcm_dma_feeder.sv
// pcm_dma_feeder: Avalon-MM DMA streaming stereo PCM words from memory into the playback FIFOWR register.
// Optional ring playback (CONTROL.LOOP) is built only when PCMDMA_LOOP_EN is defined.
module pcm_dma_feeder #(
    parameter int          BURST_WORDS    = 256,
    parameter int          SETTLE_CYCLES  = 4,
    parameter logic [31:0] PCM_WR_ADDRESS = 32'h0000_0008
) (
    input  logic        csi_clk,
    input  logic        csi_reset,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic        ins_irq,
    output logic [31:0] avm_rd_address,
    output logic        avm_rd_read,
    input  logic        avm_rd_waitrequest,
    input  logic [31:0] avm_rd_readdata,
    input  logic        avm_rd_readdatavalid,
    output logic [31:0] avm_wr_address,
    output logic        avm_wr_write,
    output logic [31:0] avm_wr_writedata,
    input  logic        avm_wr_waitrequest,
    input  logic        coe_pcm_req
);
    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_WAITREQ, S_RDREQ, S_RDDATA, S_WRREQ, S_SETTLE} state_t;

    state_t        state, state_n;
    logic          irqena, done, busy, abort_pend, loop;
    logic [31:0]   addr, length, remain, waddr, wdata;
    logic [BW-1:0] bcnt;
    logic [SW-1:0] scnt;
    logic          ctrl_wr, start_ok, abort_wr, wr_ack, last, done_set;
    logic          unused_bits;

    assign ctrl_wr     = avs_write && avs_address == 2'd0;
    assign start_ok    = ctrl_wr && avs_writedata[0] && !busy;
    assign abort_wr    = ctrl_wr && !avs_writedata[0] && busy;
    assign wr_ack      = state == S_WRREQ && !avm_wr_waitrequest;
    assign last        = remain == 32'd1;
    // BUSY in IDLE only exists for the one cycle right after START
    assign done_set    = (state == S_IDLE && busy && remain == 32'd0) || (wr_ack && last);
    assign unused_bits = ^{avs_read, avs_writedata[30:2]};

`ifdef PCMDMA_LOOP_EN
    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) loop <= 1'b0;
        else if (ctrl_wr) loop <= avs_writedata[2];
    end
`else
    assign loop = 1'b0;
`endif

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) state <= S_IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (busy) state_n = (remain == 32'd0) ? S_IDLE : S_WAITREQ;
            S_WAITREQ: state_n = abort_pend ? S_IDLE : coe_pcm_req ? S_RDREQ : S_WAITREQ;
            S_RDREQ:   if (!avm_rd_waitrequest) state_n = S_RDDATA;
            S_RDDATA:  if (avm_rd_readdatavalid) state_n = abort_pend ? S_IDLE : S_WRREQ;
            S_WRREQ:   if (!avm_wr_waitrequest)
                           state_n = (abort_pend || (last && !loop)) ? S_IDLE :
                                     (last || bcnt == BW'(1)) ? S_SETTLE : S_RDREQ;
            S_SETTLE:  state_n = abort_pend ? S_IDLE : (scnt == SW'(SETTLE_CYCLES - 1)) ? S_WAITREQ : S_SETTLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_comb begin
        avm_rd_read      = state == S_RDREQ;
        avm_wr_write     = state == S_WRREQ;
        avm_rd_address   = waddr;
        avm_wr_address   = PCM_WR_ADDRESS;
        avm_wr_writedata = wdata;
        ins_irq          = irqena && done;
        avs_readdata     = avs_address == 2'd0 ? {irqena, 28'd0, loop, done, busy} :
                           avs_address == 2'd1 ? addr :
                           avs_address == 2'd2 ? length : remain;
    end

    always_ff @(posedge csi_clk or posedge csi_reset) begin
        if (csi_reset) begin
            irqena     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            abort_pend <= 1'b0;
            addr       <= '0;
            length     <= '0;
            remain     <= '0;
            waddr      <= '0;
            wdata      <= '0;
            bcnt       <= '0;
            scnt       <= '0;
        end else begin
            if (ctrl_wr) irqena <= avs_writedata[31];
            if (avs_write && avs_address == 2'd1 && !busy) addr <= {avs_writedata[31:2], 2'b00};
            if (avs_write && avs_address == 2'd2 && !busy) length <= avs_writedata;
            done       <= done_set || (done && !(ctrl_wr && avs_writedata[1]));
            busy       <= start_ok || state_n != S_IDLE;
            abort_pend <= state_n != S_IDLE && (abort_pend || abort_wr);
            if (start_ok) begin
                waddr  <= addr;
                remain <= length;
            end else if (wr_ack) begin
                waddr  <= (last && loop) ? addr : waddr + 32'd4;
                remain <= (last && loop) ? length : remain - 32'd1;
            end
            bcnt <= (state == S_WAITREQ) ? ((remain < 32'(BURST_WORDS)) ? remain[BW-1:0] : BW'(BURST_WORDS)) :
                    wr_ack ? bcnt - 1'b1 : bcnt;
            scnt <= (state == S_SETTLE) ? scnt + 1'b1 : '0;
            // a read completing after an abort is drained but its data dropped
            if (state == S_RDDATA && avm_rd_readdatavalid && !abort_pend) wdata <= avm_rd_readdata;
        end
    end
endmodule
